div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage of the 5-stage MIPS pipeline. It takes the two register operands that the ID/EX pipeline register delivers to EX and returns quotient and remainder for DIV/DIVU. The result is written to HI/LO. While a division is in flight, the block holds a stall request so the pipeline controller freezes PC through EX.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared divider definitions: operand width, DIV FSM states and handshake levels.
package div_unit_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the EX stage.
// Result is {remainder -> HI, quotient -> LO}; stallreq_out freezes the pipe meanwhile.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        signed_div_in,
    input  logic [REG_DATA_WIDTH-1:0]   opdata1_in,
    input  logic [REG_DATA_WIDTH-1:0]   opdata2_in,
    input  logic                        start_in,
    input  logic                        annul_in,
    output logic [2*REG_DATA_WIDTH-1:0] result_out,
    output logic                        ready_out,
    output logic                        stallreq_out
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] diff;
    logic [64:0] step;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // State register and working registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic, one restoring iteration and final sign correction.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        // Bit 64 is always zero before a compare (partial remainder < 2^31 before
        // the last shift), so including it keeps the 33-bit subtract exact.
        diff = {work_q[64], work_q[63:32]} - {1'b0, divisor_q};
        step = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};

        quot_fin = neg_quot_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fin  = neg_rem_q  ? (~step[64:33] + 32'd1) : step[64:33];

        abs_a = (signed_div_in && opdata1_in[31]) ? (~opdata1_in + 32'd1) : opdata1_in;
        abs_b = (signed_div_in && opdata2_in[31]) ? (~opdata2_in + 32'd1) : opdata2_in;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_in == DIV_START && !annul_in) begin
                    if (opdata2_in == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        work_d     = {32'b0, abs_a, 1'b0};
                        divisor_d  = abs_b;
                        neg_quot_d = signed_div_in & (opdata1_in[31] ^ opdata2_in[31]);
                        neg_rem_d  = signed_div_in & opdata1_in[31];
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_in) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_in) begin
                    state_d = DIV_IDLE;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DIV_END;
                        result_d = {rem_fin, quot_fin};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (start_in == DIV_STOP) begin
                    state_d  = DIV_IDLE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign result_out   = result_q;
    assign ready_out    = ready_q;
    assign stallreq_out = start_in & ~ready_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor pops on ready rise.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signed_div_in;
    logic [31:0] opdata1_in;
    logic [31:0] opdata2_in;
    logic        start_in;
    logic        annul_in;
    logic [63:0] result_out;
    logic        ready_out;
    logic        stallreq_out;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic prev_ready = 1'b0;

    div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_in(signed_div_in),
        .opdata1_in   (opdata1_in),
        .opdata2_in   (opdata2_in),
        .start_in     (start_in),
        .annul_in     (annul_in),
        .result_out   (result_out),
        .ready_out    (ready_out),
        .stallreq_out (stallreq_out)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic, truncating division; divide by zero gives zeros.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        if (y == 32'd0) return 64'd0;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            return {r[31:0], q[31:0]};
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: one comparison per rising ready_out.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready = 1'b0;
        end else begin
            if (ready_out && !prev_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h expected=none", result_out);
                end else begin
                    chk("result", result_out, sb_q.pop_front());
                end
            end
            prev_ready = ready_out;
        end
    end

    task automatic run_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                           input logic rst_in_end);
        int edges;
        int stalls;
        int exp_lat;
        @(negedge clk);
        signed_div_in = sgn;
        opdata1_in    = x;
        opdata2_in    = y;
        start_in      = 1'b1;
        sb_q.push_back(model(sgn, x, y));
        exp_lat = (y == 32'd0) ? 2 : 33;
        edges   = 0;
        stalls  = 0;
        while (1) begin
            #1;
            if (stallreq_out) stalls++;
            @(posedge clk);
            #1;
            edges++;
            if (ready_out || edges >= 40) break;
            @(negedge clk);
        end
        chk("latency", 64'(edges), 64'(exp_lat));
        chk("stall_cycles", 64'(stalls), 64'(exp_lat));
        chk("stall_drop", 64'(stallreq_out), 64'd0);
        opdata1_in = $urandom;
        opdata2_in = $urandom;
        if (rst_in_end) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_end_ready", 64'(ready_out), 64'd0);
            chk("rst_end_result", result_out, 64'd0);
            start_in = 1'b0;
            @(negedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            start_in = 1'b0;
            @(posedge clk);
            #1;
            chk("ready_clear", 64'(ready_out), 64'd0);
            chk("result_clear", result_out, 64'd0);
        end
    endtask

    task automatic count_ready(input string nm, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (ready_out) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        int          sel;

        rst_n         = 1'b0;
        start_in      = 1'b0;
        annul_in      = 1'b0;
        signed_div_in = 1'b0;
        opdata1_in    = '0;
        opdata2_in    = '0;
        #2;
        chk("reset_ready", 64'(ready_out), 64'd0);
        chk("reset_result", result_out, 64'd0);
        chk("reset_stall", 64'(stallreq_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 1'b0);
        run_div(1'b1, -32'sd7, 32'd2, 1'b0);
        run_div(1'b1, 32'd7, -32'sd2, 1'b0);
        run_div(1'b1, 32'd5, 32'd0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Annul on the 10th ON cycle of 1000/3.
        @(negedge clk);
        signed_div_in = 1'b0;
        opdata1_in    = 32'd1000;
        opdata2_in    = 32'd3;
        start_in      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_in = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_ready", 64'(ready_out), 64'd0);
        @(negedge clk);
        annul_in = 1'b0;
        start_in = 1'b0;
        count_ready("annul_no_ready", 40);
        run_div(1'b0, 32'd9, 32'd4, 1'b0);

        // Asynchronous reset between edges while in ON.
        @(negedge clk);
        signed_div_in = 1'b0;
        opdata1_in    = 32'd12345;
        opdata2_in    = 32'd17;
        start_in      = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        start_in = 1'b0;
        #1;
        chk("rst_on_ready", 64'(ready_out), 64'd0);
        chk("rst_on_result", result_out, 64'd0);
        chk("rst_on_stall", 64'(stallreq_out), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        count_ready("rst_no_ready", 40);

        // Asynchronous reset while holding a finished result.
        run_div(1'b1, 32'd1000, -32'sd3, 1'b1);
        run_div(1'b0, 32'd9, 32'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            x   = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = -32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            run_div(sgn, x, y, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_unit
